// File: rtl/vsq_buffer_if.sv
// Handshake, forward, read-out and status bundle between upstream, vsq_buffer and the quantizer.
// master = upstream/quantizer side, slave = buffer side.
interface vsq_buffer_if #(
  parameter int LANES = 16,
  parameter int DW    = 40,
  parameter int AW    = 6
);
  logic                  i_valid;
  logic                  o_ready;
  logic [LANES*DW-1:0]   i_data;
  logic [LANES*DW-1:0]   o_run_data;
  logic                  o_start;
  logic [AW-1:0]         i_buf_addr;
  logic [LANES*DW-1:0]   o_buf_data;
  logic                  i_sf_valid;
  logic [AW:0]           o_fill_cnt;
  logic                  o_err;

  modport master (
    output i_valid, i_data, i_buf_addr, i_sf_valid,
    input  o_ready, o_run_data, o_start, o_buf_data, o_fill_cnt, o_err
  );

  modport slave (
    input  i_valid, i_data, i_buf_addr, i_sf_valid,
    output o_ready, o_run_data, o_start, o_buf_data, o_fill_cnt, o_err
  );
endinterface

// File: rtl/vsq_buffer.sv
// Staging buffer for one 64-vector group ahead of the INT4 quantizer: accepts are forwarded in 0 cycles and
// readable 1 cycle later; o_ready drops after the 64th vector and returns only after the quantizer's scale-factor pulse.
module vsq_buffer #(
  parameter int LANES = 16,
  parameter int DW    = 40,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  vsq_buffer_if.slave bus
);

  localparam int VW = LANES * DW;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t         state;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    fill_cnt;
  logic           ready_q;
  logic           start_q;
  logic           err_q;
  logic           accept;

  logic [VW-1:0]  mem [DEPTH];

  // ready_q mirrors (state == FILL) so i_valid never reaches o_ready
  assign accept = bus.i_valid & ready_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= FILL;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      ready_q  <= 1'b1;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (bus.i_sf_valid && (state != WAIT)) begin
        err_q <= 1'b1;
      end
      case (state)
        FILL: begin
          if (accept) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            fill_cnt <= fill_cnt + CNT_ONE;
            if (wr_ptr == PTR_LAST) begin
              state   <= START;
              ready_q <= 1'b0;
              start_q <= 1'b1;
            end
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.i_sf_valid) begin
            state    <= FILL;
            fill_cnt <= '0;
            ready_q  <= 1'b1;
          end
        end
        default: begin
          state   <= FILL;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; a read of the address being written returns the old word
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem[wr_ptr] <= bus.i_data;
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_run_data = accept ? bus.i_data : '0;
  assign bus.o_start    = start_q;
  assign bus.o_buf_data = mem[bus.i_buf_addr];
  assign bus.o_fill_cnt = fill_cnt;
  assign bus.o_err      = err_q;

endmodule
